valu_seq: RTL
=============

VALU_SEQ -- requirements
Module: valu_seq

Interface
REQ-001 SHALL have parameter LEN_W, default 8, giving the width of the command length field.
REQ-002 SHALL have port clk_i  input  1  clock; all state is updated on the rising edge.
REQ-003 SHALL have port rst_i  input  1  asynchronous reset, active-high.
REQ-004 SHALL have port cmd_valid_i  input  1  command request.
REQ-005 SHALL have port cmd_ready_o  output  1  command accepted when both valid and ready are high at a clock edge.
REQ-006 SHALL have port cmd_len_i  input  LEN_W  number of operand word pairs to process.
REQ-007 SHALL have port cmd_bias_i  input  32  initial accumulator value.
REQ-008 SHALL have port op_valid_i / op_ready_o  input/output  1/1  operand stream handshake.
REQ-009 SHALL have port op_a_i, op_b_i  input  32 each  packed 4x8-bit operand words.
REQ-010 SHALL have port valu_operand_a_o, valu_operand_b_o  output  32 each  registered operands driven to the vector ALU.
REQ-011 SHALL have port valu_result_i  input  32  combinational dot-product result returned from the vector ALU.
REQ-012 SHALL have port valu_ready_i  input  1  vector ALU ready.
REQ-013 SHALL have port res_valid_o / res_ready_i  output/input  1/1  result handshake.
REQ-014 SHALL have port res_data_o  output  32  final accumulator value.
REQ-015 SHALL have port res_ovf_o  output  1  sticky signed-overflow flag for the current command.
REQ-016 SHALL have port busy_o  output  1  high in every state other than IDLE.

Function
REQ-017 SHALL implement the FSM states IDLE, RUN, DRAIN and DONE.
REQ-018 SHALL drive cmd_ready_o = 1 only in IDLE; a command presented in any other state is held off.
REQ-019 On cmd handshake: acc <= cmd_bias_i, remaining <= cmd_len_i, ovf <= 0, and the state becomes RUN, or DONE directly if cmd_len_i == 0.
REQ-020 SHALL drive op_ready_o = (state == RUN) && (remaining != 0) && valu_ready_i.
REQ-021 On op handshake: valu_operand_a_o <= op_a_i, valu_operand_b_o <= op_b_i, pipe_valid <= 1, remaining <= remaining - 1.
REQ-022 With no op handshake, pipe_valid SHALL clear at the next edge and the valu_operand_* outputs SHALL hold their values.
REQ-023 While pipe_valid is high, each edge SHALL update acc <= acc + valu_result_i, using modulo-2^32 wrap-around.
REQ-024 ovf SHALL be set when the accumulate operands have equal sign and the sum sign differs from them; once set, ovf stays set until the next command.
REQ-025 Throughput SHALL be one operand pair per cycle; the accumulate happens at the edge after acceptance, so latency is 1 cycle.
REQ-026 RUN SHALL go to DRAIN at the edge that accepts the last pair (remaining 1 -> 0).
REQ-027 DRAIN SHALL go to DONE at the next edge, where the final accumulate occurs.
REQ-028 In DONE: res_valid_o = 1, res_data_o = acc, res_ovf_o = ovf.
REQ-029 A res handshake SHALL return the FSM to IDLE.
REQ-030 res_valid_o SHALL stay high, with res_data_o and res_ovf_o stable, until res_ready_i is seen.
REQ-031 If valu_ready_i is low in RUN, no pair SHALL be accepted, remaining is unchanged and an in-flight accumulate still completes.
REQ-032 op_valid_i SHALL be ignored outside RUN and when remaining == 0.
REQ-033 A cmd_len_i at its maximum value (2^LEN_W - 1) SHALL be processed fully, without counter wrap.

Reset
REQ-034 While rst_i is high, and immediately on its assertion, the block SHALL hold: state = IDLE, acc = 0, remaining = 0, pipe_valid = 0, ovf = 0, valu_operand_a_o = 0, valu_operand_b_o = 0.
REQ-035 The outputs in reset SHALL be: cmd_ready_o = 0, op_ready_o = 0, res_valid_o = 0, busy_o = 0, res_data_o = 0, res_ovf_o = 0.
REQ-036 Reset asserted mid-command SHALL abandon the command with no result output; the first cycle after release is IDLE with cmd_ready_o = 1.

Verification
REQ-037 Basic: bias = 10, len = 3, op_a = op_b = 0x01010101 each cycle, valu modeled -> cmd accepted at E0, ops at E1-E3, res_valid_o from E4, res_data_o = 22, res_ovf_o = 0.
REQ-038 Zero length: len = 0, bias = 0xDEADBEEF -> res_valid_o one cycle after the cmd handshake, res_data_o = 0xDEADBEEF, op_ready_o never high.
REQ-039 Stall and backpressure: len = 2, valu_ready_i low for 3 cycles between the pairs, res_ready_i low for 4 cycles -> res_data_o = bias + both products, held stable throughout, with a single res handshake.
REQ-040 Overflow: bias = 0x7FFFFFF0, one pair with result +0x20 -> res_data_o = 0x80000010, res_ovf_o = 1; the next command starts with res_ovf_o = 0.
REQ-041 Reset mid-RUN: after 2 of 5 pairs, pulse rst_i -> all outputs at reset values immediately; a new command (len = 1, bias = 0) yields the single product only.
REQ-042 Command in DONE: cmd_valid_i held high during DONE -> cmd_ready_o = 0 until the cycle after the res handshake, then the command is accepted.

Source files
------------

// File: rtl/valu_seq.sv
// valu_seq -- command sequencer for an external vector ALU.
//
// Takes a command (length, bias) and then streams `length` operand pairs
// into the vector ALU through registered operand outputs. Each
// combinational ALU result is added into a 32-bit accumulator one cycle
// after its pair is accepted. When all pairs are in, the final
// accumulator and a sticky signed-overflow flag are presented on the
// result handshake.
//
// Ports
//   clk_i, rst_i                       clock, async active-high reset
//   cmd_valid_i/cmd_ready_o            command handshake
//   cmd_len_i, cmd_bias_i              pair count, initial accumulator
//   op_valid_i/op_ready_o              operand stream handshake
//   op_a_i, op_b_i                     packed 4x8-bit operand words
//   valu_operand_a_o/_b_o              registered operands to the ALU
//   valu_result_i, valu_ready_i        ALU result (combinational), ALU ready
//   res_valid_o/res_ready_i            result handshake
//   res_data_o, res_ovf_o              final accumulator, overflow flag
//   busy_o                             high whenever not IDLE
//
// state | meaning
// IDLE  | waiting for a command
// RUN   | accepting operand pairs
// DRAIN | last pair accepted, final accumulate pending
// DONE  | result presented until res_ready_i

module valu_seq #(
  parameter int LEN_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             cmd_valid_i,
  output logic             cmd_ready_o,
  input  logic [LEN_W-1:0] cmd_len_i,
  input  logic [31:0]      cmd_bias_i,
  input  logic             op_valid_i,
  output logic             op_ready_o,
  input  logic [31:0]      op_a_i,
  input  logic [31:0]      op_b_i,
  output logic [31:0]      valu_operand_a_o,
  output logic [31:0]      valu_operand_b_o,
  input  logic [31:0]      valu_result_i,
  input  logic             valu_ready_i,
  output logic             res_valid_o,
  input  logic             res_ready_i,
  output logic [31:0]      res_data_o,
  output logic             res_ovf_o,
  output logic             busy_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t           state;
  logic [31:0]      acc;
  logic [LEN_W-1:0] remaining;
  logic             pipe_valid;
  logic             ovf;

  logic             cmd_hs;
  logic             op_hs;
  logic [31:0]      sum;
  logic             sum_ovf;

  // State sits at IDLE during reset, so ready is masked by rst_i to keep
  // the block from advertising itself while reset is held.
  assign cmd_ready_o = (state == IDLE) && !rst_i;
  assign op_ready_o  = (state == RUN) && (remaining != '0) && valu_ready_i;
  assign cmd_hs      = cmd_ready_o && cmd_valid_i;
  assign op_hs       = op_ready_o && op_valid_i;

  assign sum     = acc + valu_result_i;
  assign sum_ovf = (acc[31] == valu_result_i[31]) && (sum[31] != acc[31]);

  assign busy_o      = (state != IDLE);
  assign res_valid_o = (state == DONE);
  assign res_data_o  = (state == DONE) ? acc : 32'd0;
  assign res_ovf_o   = (state == DONE) && ovf;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state            <= IDLE;
      acc              <= 32'd0;
      remaining        <= '0;
      pipe_valid       <= 1'b0;
      ovf              <= 1'b0;
      valu_operand_a_o <= 32'd0;
      valu_operand_b_o <= 32'd0;
    end else begin
      // Accumulate the pair accepted on the previous edge; this runs in
      // RUN or DRAIN regardless of whether a new pair is being taken.
      if (pipe_valid) begin
        acc <= sum;
        if (sum_ovf) ovf <= 1'b1;
      end

      pipe_valid <= op_hs;
      if (op_hs) begin
        valu_operand_a_o <= op_a_i;
        valu_operand_b_o <= op_b_i;
        remaining        <= remaining - 1'b1;
      end

      case (state)
        IDLE: begin
          // pipe_valid is always low in IDLE, so these loads never
          // collide with an accumulate.
          if (cmd_hs) begin
            acc       <= cmd_bias_i;
            remaining <= cmd_len_i;
            ovf       <= 1'b0;
            state     <= (cmd_len_i == '0) ? DONE : RUN;
          end
        end
        RUN: begin
          if (op_hs && (remaining == LEN_W'(1))) state <= DRAIN;
        end
        DRAIN: begin
          state <= DONE;
        end
        DONE: begin
          if (res_ready_i) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
